// File: rtl/morse_keyer_if.sv
// Character handshake between the character source and the morse keyer.
// The source drives the character and its pattern; the keyer returns a one-cycle pop strobe.
interface morse_keyer_if;
    logic       char_valid;
    logic [6:0] char_ascii;
    logic [6:0] morse_value;
    logic [2:0] morse_len;
    logic       char_ready;

    modport master (
        output char_valid,
        output char_ascii,
        output morse_value,
        output morse_len,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_ascii,
        input  morse_value,
        input  morse_len,
        output char_ready
    );
endinterface

// File: rtl/morse_keyer.sv
// Morse timing sequencer: accepts one character per handshake, keys dot/dash/gap
// units from a prescaled clock, and echoes every accepted character.
module morse_keyer #(
    parameter int CLK_UNITS = 1_000_000,
    parameter int UNIT_W    = 24
) (
    input  logic                 clk_24,
    input  logic                 rst_n,
    morse_keyer_if.slave         chr,
    input  logic                 abort,
    output logic                 key_out,
    output logic                 echo_valid,
    output logic [7:0]           echo_data,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MARK     = 2'd1,
        ELEM_GAP = 2'd2,
        CHAR_GAP = 2'd3
    } state_t;

    state_t            state_r;
    logic [UNIT_W-1:0] presc_r;
    logic [2:0]        units_r;
    logic [2:0]        idx_r;
    logic [2:0]        len_r;
    logic [6:0]        value_r;
    logic              char_ready_r;

    logic              tick_s;
    logic              last_s;
    logic [2:0]        idx_next_s;

    assign tick_s         = (presc_r == UNIT_W'(CLK_UNITS - 1));
    assign last_s         = tick_s && (units_r == 3'd1);
    assign idx_next_s     = idx_r + 3'd1;
    assign chr.char_ready = char_ready_r;

    // Sequencer FSM with prescaler, unit counter and registered outputs.
    always_ff @(posedge clk_24 or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            presc_r      <= '0;
            units_r      <= 3'd0;
            idx_r        <= 3'd0;
            len_r        <= 3'd0;
            value_r      <= 7'd0;
            char_ready_r <= 1'b0;
            key_out      <= 1'b0;
            echo_valid   <= 1'b0;
            echo_data    <= 8'd0;
            busy         <= 1'b0;
        end else begin
            char_ready_r <= 1'b0;
            echo_valid   <= 1'b0;
            case (state_r)
                IDLE: begin
                    key_out <= 1'b0;
                    busy    <= 1'b0;
                    presc_r <= '0;
                    idx_r   <= 3'd0;
                    // The pop cycle launches timing from the pattern latched one cycle earlier.
                    if (char_ready_r) begin
                        if (abort) begin
                            state_r <= IDLE;
                        end else if (echo_data[6:0] == 7'd32) begin
                            state_r <= CHAR_GAP;
                            units_r <= 3'd4;
                            busy    <= 1'b1;
                        end else if (len_r == 3'd0) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= MARK;
                            units_r <= value_r[0] ? 3'd3 : 3'd1;
                            key_out <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end else if (chr.char_valid && !abort) begin
                        char_ready_r <= 1'b1;
                        echo_valid   <= 1'b1;
                        echo_data    <= {1'b0, chr.char_ascii};
                        value_r      <= chr.morse_value;
                        len_r        <= chr.morse_len;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    if (abort) begin
                        state_r <= IDLE;
                        presc_r <= '0;
                        key_out <= 1'b0;
                        busy    <= 1'b0;
                    end else if (last_s) begin
                        presc_r <= '0;
                        case (state_r)
                            MARK: begin
                                idx_r   <= idx_next_s;
                                key_out <= 1'b0;
                                if (idx_next_s == len_r) begin
                                    state_r <= CHAR_GAP;
                                    units_r <= 3'd3;
                                end else begin
                                    state_r <= ELEM_GAP;
                                    units_r <= 3'd1;
                                end
                            end
                            ELEM_GAP: begin
                                state_r <= MARK;
                                units_r <= value_r[idx_r] ? 3'd3 : 3'd1;
                                key_out <= 1'b1;
                            end
                            default: begin
                                state_r <= IDLE;
                                key_out <= 1'b0;
                                busy    <= 1'b0;
                            end
                        endcase
                    end else if (tick_s) begin
                        units_r <= units_r - 3'd1;
                        presc_r <= '0;
                    end else begin
                        presc_r <= presc_r + UNIT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer with CLK_UNITS=4: per-cycle traces are captured
// and compared against hand-computed unit timings.
module tb_morse_keyer;

    logic       clk_24 = 1'b0;
    logic       rst_n  = 1'b0;
    logic       abort  = 1'b0;
    logic       key_out;
    logic       echo_valid;
    logic [7:0] echo_data;
    logic       busy;

    morse_keyer_if chr_if();

    morse_keyer #(.CLK_UNITS(4), .UNIT_W(4)) dut (
        .clk_24     (clk_24),
        .rst_n      (rst_n),
        .chr        (chr_if.slave),
        .abort      (abort),
        .key_out    (key_out),
        .echo_valid (echo_valid),
        .echo_data  (echo_data),
        .busy       (busy)
    );

    always #5 clk_24 = ~clk_24;

    int n_cmp = 0;
    int n_bad = 0;

    // trace bits: 3 char_ready, 2 echo_valid, 1 busy, 0 key_out
    logic [3:0] tr [0:127];
    logic       have_next = 1'b0;
    logic [6:0] nx_ascii, nx_value;
    logic [2:0] nx_len;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_24);
        #1;
    endtask

    task automatic send(logic [6:0] a, logic [6:0] v, logic [2:0] l);
        chr_if.char_ascii  = a;
        chr_if.morse_value = v;
        chr_if.morse_len   = l;
        chr_if.char_valid  = 1'b1;
    endtask

    function automatic int cnt(int b, int lo, int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) c += int'(tr[i][b]);
        return c;
    endfunction

    // Runs n cycles as a well-behaved source: holds data until popped, then
    // presents the queued character or drops char_valid.
    task automatic capture(int n);
        logic prev_ready;
        prev_ready = 1'b0;
        for (int i = 0; i < 128; i++) tr[i] = 4'd0;
        for (int i = 0; i < n; i++) begin
            step();
            if (prev_ready) begin
                if (have_next) begin
                    send(nx_ascii, nx_value, nx_len);
                    have_next = 1'b0;
                end else begin
                    chr_if.char_valid = 1'b0;
                end
            end
            tr[i] = {chr_if.char_ready, echo_valid, busy, key_out};
            prev_ready = chr_if.char_ready;
        end
    endtask

    initial begin
        chr_if.char_valid  = 1'b0;
        chr_if.char_ascii  = 7'd0;
        chr_if.morse_value = 7'd0;
        chr_if.morse_len   = 3'd0;
        #23;
        rst_n = 1'b1;
        step();
        check("rst_key",   {31'd0, key_out},    32'd0);
        check("rst_busy",  {31'd0, busy},       32'd0);
        check("rst_echo",  {31'd0, echo_valid}, 32'd0);
        check("rst_ready", {31'd0, chr_if.char_ready}, 32'd0);
        check("rst_data",  {24'd0, echo_data},  32'd0);

        // 1: 'A' dot-dash
        send(7'h41, 7'b0000010, 3'd2);
        capture(40);
        check("A_ready0",   {31'd0, tr[0][3]}, 32'd1);
        check("A_echo_n",   cnt(2, 0, 39),     32'd1);
        check("A_echo_dat", {24'd0, echo_data}, 32'h41);
        check("A_dot",      cnt(0, 1, 4),      32'd4);
        check("A_gap",      cnt(0, 5, 8),      32'd0);
        check("A_dash",     cnt(0, 9, 20),     32'd12);
        check("A_key_tot",  cnt(0, 0, 39),     32'd16);
        check("A_busy_tot", cnt(1, 0, 39),     32'd32);
        check("A_busy_win", cnt(1, 1, 32),     32'd32);

        // 2: 'E' then 'T' back to back
        nx_ascii = 7'h54; nx_value = 7'b0000001; nx_len = 3'd1; have_next = 1'b1;
        send(7'h45, 7'b0000000, 3'd1);
        capture(50);
        check("ET_busy16",  {31'd0, tr[16][1]}, 32'd1);
        check("ET_busy17",  {31'd0, tr[17][1]}, 32'd0);
        check("ET_ready18", {31'd0, tr[18][3]}, 32'd1);
        check("ET_e_dot",   cnt(0, 1, 4),       32'd4);
        check("ET_lowgap",  cnt(0, 5, 18),      32'd0);
        check("ET_t_dash",  cnt(0, 19, 30),     32'd12);
        check("ET_key_tot", cnt(0, 0, 49),      32'd16);
        check("ET_echo_n",  cnt(2, 0, 49),      32'd2);
        check("ET_dat",     {24'd0, echo_data}, 32'h54);

        // 3: space
        send(7'd32, 7'b0000000, 3'd0);
        capture(25);
        check("SP_dat",    {24'd0, echo_data}, 32'h20);
        check("SP_key",    cnt(0, 0, 24),      32'd0);
        check("SP_busy",   cnt(1, 0, 24),      32'd16);
        check("SP_busy17", {31'd0, tr[17][1]}, 32'd0);

        // 4: abort 5 cycles into a dash
        send(7'h54, 7'b0000001, 3'd1);
        capture(6);
        check("AB_key_pre", cnt(0, 1, 5), 32'd5);
        abort = 1'b1;
        step();
        check("AB_key",  {31'd0, key_out},    32'd0);
        check("AB_busy", {31'd0, busy},       32'd0);
        check("AB_echo", {31'd0, echo_valid}, 32'd0);
        abort = 1'b0;
        capture(20);
        check("AB_quiet", {28'd0, 4'(cnt(0, 0, 19) + cnt(1, 0, 19) + cnt(2, 0, 19))}, 32'd0);
        abort = 1'b1;
        send(7'h45, 7'b0000000, 3'd1);
        capture(3);
        check("AB_idle_supp", cnt(3, 0, 2) + cnt(2, 0, 2), 32'd0);
        abort = 1'b0;
        capture(20);
        check("AB_next_echo", cnt(2, 0, 19),      32'd1);
        check("AB_next_key",  cnt(0, 0, 19),      32'd4);
        check("AB_next_dat",  {24'd0, echo_data}, 32'h45);

        // 5: asynchronous reset mid-MARK
        send(7'h54, 7'b0000001, 3'd1);
        capture(4);
        check("RS_key_pre", {31'd0, key_out}, 32'd1);
        #2;
        rst_n = 1'b0;
        chr_if.char_valid = 1'b0;
        #1;
        check("RS_key_async",  {31'd0, key_out}, 32'd0);
        check("RS_busy_async", {31'd0, busy},    32'd0);
        #20;
        rst_n = 1'b1;
        step();
        check("RS_dat",  {24'd0, echo_data}, 32'd0);
        check("RS_busy", {31'd0, busy},      32'd0);

        // 6: len=0 character
        send(7'h23, 7'b0000000, 3'd0);
        capture(20);
        check("L0_ready", cnt(3, 0, 19),      32'd1);
        check("L0_echo",  cnt(2, 0, 19),      32'd1);
        check("L0_key",   cnt(0, 0, 19),      32'd0);
        check("L0_busy",  cnt(1, 0, 19),      32'd0);
        check("L0_dat",   {24'd0, echo_data}, 32'h23);

        // len=7 pattern: 4 dashes, 3 dots, 6 element gaps, char gap
        send(7'h5A, 7'b1010101, 3'd7);
        capture(110);
        check("L7_key",    cnt(0, 0, 109),    32'd60);
        check("L7_busy",   cnt(1, 0, 109),    32'd96);
        check("L7_busy96", {31'd0, tr[96][1]}, 32'd1);
        check("L7_busy97", {31'd0, tr[97][1]}, 32'd0);
        check("L7_first",  cnt(0, 1, 12),     32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
- Timing sequencer between the character source (memory read side) and the morse decoder/audio driver.
- Accepts one ASCII character per valid/ready handshake, with its decoded morse pattern, and drives key_out with exact dot/dash/gap unit timing.
- Emits a one-cycle echo strobe per accepted character for the UART transmitter.
- Replaces ad-hoc timing with a defined FSM, prescaler and abort.

Parameters:
CLK_UNITS, 1_000_000, clk_24 cycles per morse unit (must be >= 2)
UNIT_W, 24, prescaler width; must hold CLK_UNITS-1

Ports:
clk_24  in  1  system clock
rst_n  in  1  asynchronous active-low reset
char_valid  in  1  character available from source
char_ascii  in  7  character code, valid with char_valid
morse_value  in  7  decoded pattern, bit i = element i, 1=dash 0=dot; valid with char_valid
morse_len  in  3  element count 0..7; valid with char_valid
char_ready  out  1  one-cycle pop strobe; handshake completes when char_valid & char_ready
abort  in  1  synchronous flush of the character in progress
key_out  out  1  tone enable to audio driver
echo_valid  out  1  one-cycle strobe per accepted character
echo_data  out  8  {1'b0, char_ascii} of the accepted character, held until next accept
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; key_out, char_ready, echo_valid, busy = 0; echo_data = 0; prescaler, unit counter and element index = 0. Reset mid-element drops key_out immediately.
- States: IDLE, MARK, ELEM_GAP, CHAR_GAP.
- Prescaler: cleared on every state entry; counts 0..CLK_UNITS-1. tick = (count == CLK_UNITS-1). A unit counter is decremented on tick; the state exits on the tick where it equals 1. A state loaded with N units therefore lasts exactly N*CLK_UNITS cycles.
- IDLE, char_valid=1, abort=0:
  - char_ready=1 for that cycle (registered: asserted the cycle after char_valid is seen; char_valid and data are held until then).
  - Latch value, len and ascii.
  - echo_valid=1 for exactly one cycle, coincident with char_ready; echo_data updated.
- Next state after accept:
  - ascii==32: CHAR_GAP with 4 units, giving 7 units with the preceding 3.
  - len==0 (non-space): back to IDLE; echoed only, no timing.
  - otherwise: MARK, idx=0, units = value[0] ? 3 : 1.
- MARK: key_out=1. On exit, idx increments. If new idx == len, go to CHAR_GAP with 3 units; else go to ELEM_GAP with 1 unit.
- ELEM_GAP: key_out=0. On exit, go to MARK with units = value[idx] ? 3 : 1.
- CHAR_GAP: key_out=0. On exit, go to IDLE. The next character may be accepted the cycle after IDLE is entered.
- key_out is registered and equals (state==MARK); no glitches.
- abort: in any non-IDLE state, go to IDLE next cycle with key_out=0 and no echo. In IDLE, abort suppresses acceptance; abort beats char_valid in the same cycle.
- Input sampling: inputs other than char_valid/abort are only sampled at accept; later changes are ignored.
- Width rules: idx is 3 bits; the compare with len is 3-bit unsigned; len=7 is valid (idx reaches 7 with no overflow).

Test Plan:
1. CLK_UNITS=4, 'A' (value=7'b0000010, len=2) -> one echo_valid with echo_data=8'h41; key_out high 4, low 4, high 12, then low; busy high for 4+4+12+12=32 cycles after accept.
2. 'E' (len=1, value=0) followed immediately by 'T' (len=1, value=1), char_valid held -> second char_ready exactly 1 cycle after busy falls; key_out pulses of 4 and 12 cycles separated by 12 low cycles plus 2 handshake cycles.
3. Space (ascii=32) -> echo_data=8'h20; key_out stays 0; busy high 16 cycles.
4. abort asserted 5 cycles into a dash -> key_out 0 and busy 0 on the next cycle; no extra echo; the next valid char is accepted normally.
5. rst_n pulsed low asynchronously mid-MARK -> key_out and busy fall without a clock edge; after release, state IDLE and echo_data=0.
6. len=0, ascii=8'h23 -> char_ready and echo_valid pulse once; key_out never asserts; busy stays 0 after the accept cycle.
